// File: rtl/sd_cmd_phy_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_phy_if
// Description : Command-controller / PAD-side signal bundle for sd_cmd_phy.
//               master = command controller plus PAD return path,
//               slave  = the serial command-line engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_cmd_phy_if;
  // Command request
  logic        tx_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        resp_expected;
  logic        resp_crc_check;
  // PAD pins
  logic        pad_data_in;
  logic        pad_output_input;
  logic        pad_enable;
  logic        pad_data_out;
  // Status and results
  logic        busy;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_argument;
  logic        crc_error;
  logic        end_bit_error;
  logic        timeout_error;

  modport master (
    output tx_start, cmd_index, cmd_argument, resp_expected, resp_crc_check,
    output pad_data_out,
    input  pad_data_in, pad_output_input, pad_enable,
    input  busy, done, resp_index, resp_argument,
    input  crc_error, end_bit_error, timeout_error
  );

  modport slave (
    input  tx_start, cmd_index, cmd_argument, resp_expected, resp_crc_check,
    input  pad_data_out,
    output pad_data_in, pad_output_input, pad_enable,
    output busy, done, resp_index, resp_argument,
    output crc_error, end_bit_error, timeout_error
  );
endinterface
`default_nettype wire

// File: rtl/sd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_phy
// Description : SD CMD-line engine. Frames and serialises a 48-bit command
//               (CRC7 generated on the fly), releases the line, optionally
//               captures a 48-bit response and checks its CRC7 / end bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_phy #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TURN_CYCLES    = 2
) (
  input logic         clock,
  input logic         reset,
  sd_cmd_phy_if.slave bus
);

  // One shared counter serves SEND (48 bits), TURN, RECV and the timeout.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > 48) ? TIMEOUT_CYCLES : 48;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND       = 3'd1,
    TURN       = 3'd2,
    WAIT_START = 3'd3,
    RECV       = 3'd4,
    CHECK      = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [47:0]        sr_q, sr_d;
  logic [6:0]         crc_q, crc_d;
  logic               resp_exp_q, resp_exp_d;
  logic               crc_chk_q, crc_chk_d;
  logic [5:0]         resp_index_q, resp_index_d;
  logic [31:0]        resp_argument_q, resp_argument_d;
  logic               crc_error_q, crc_error_d;
  logic               end_bit_error_q, end_bit_error_d;
  logic               timeout_error_q, timeout_error_d;
  logic [6:0]         crc_tx_next;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  assign crc_tx_next = crc7_step(crc_q, sr_q[47]);

  // State register and datapath flops; reset returns everything to IDLE/zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sr_q            <= '0;
      crc_q           <= '0;
      resp_exp_q      <= 1'b0;
      crc_chk_q       <= 1'b0;
      resp_index_q    <= '0;
      resp_argument_q <= '0;
      crc_error_q     <= 1'b0;
      end_bit_error_q <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sr_q            <= sr_d;
      crc_q           <= crc_d;
      resp_exp_q      <= resp_exp_d;
      crc_chk_q       <= crc_chk_d;
      resp_index_q    <= resp_index_d;
      resp_argument_q <= resp_argument_d;
      crc_error_q     <= crc_error_d;
      end_bit_error_q <= end_bit_error_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  // Next-state logic: framing, shifting, CRC accumulation and result capture.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sr_d            = sr_q;
    crc_d           = crc_q;
    resp_exp_d      = resp_exp_q;
    crc_chk_d       = crc_chk_q;
    resp_index_d    = resp_index_q;
    resp_argument_d = resp_argument_q;
    crc_error_d     = crc_error_q;
    end_bit_error_d = end_bit_error_q;
    timeout_error_d = timeout_error_q;

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          // CRC field starts as zeros; it is overwritten while bit 8 goes out.
          sr_d            = {1'b0, 1'b1, bus.cmd_index, bus.cmd_argument, 7'd0, 1'b1};
          crc_d           = '0;
          cnt_d           = '0;
          resp_exp_d      = bus.resp_expected;
          crc_chk_d       = bus.resp_crc_check;
          crc_error_d     = 1'b0;
          end_bit_error_d = 1'b0;
          timeout_error_d = 1'b0;
          state_d         = SEND;
        end
      end

      SEND: begin
        sr_d = {sr_q[46:0], 1'b0};
        if (cnt_q < CNT_W'(40)) begin
          crc_d = crc_tx_next;
        end
        // Bit 8 is leaving now: the CRC is complete and slides in behind it.
        if (cnt_q == CNT_W'(39)) begin
          sr_d[47:41] = crc_tx_next;
        end
        if (cnt_q == CNT_W'(47)) begin
          cnt_d   = '0;
          state_d = TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      TURN: begin
        if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = resp_exp_q ? WAIT_START : DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_START: begin
        if (!bus.pad_data_out) begin
          // Start bit is 0, so starting the CRC from zero already accounts for it.
          sr_d    = '0;
          crc_d   = '0;
          cnt_d   = '0;
          state_d = RECV;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_error_d = 1'b1;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RECV: begin
        sr_d = {sr_q[46:0], bus.pad_data_out};
        // Counts 0..38 carry response bits 46..8, the CRC-covered field.
        if (cnt_q < CNT_W'(39)) begin
          crc_d = crc7_step(crc_q, bus.pad_data_out);
        end
        if (cnt_q == CNT_W'(46)) begin
          cnt_d   = '0;
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      CHECK: begin
        resp_index_d    = sr_q[45:40];
        resp_argument_d = sr_q[39:8];
        end_bit_error_d = ~sr_q[0];
        crc_error_d     = crc_chk_q && (crc_q != sr_q[7:1]);
        state_d         = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from state, so reset clears them immediately.
  always_comb begin
    bus.pad_enable       = (state_q != IDLE);
    bus.pad_output_input = (state_q == SEND) || ((state_q == TURN) && (cnt_q == '0));
    bus.pad_data_in      = (state_q == SEND) ? sr_q[47] : (state_q != IDLE);
    bus.busy             = (state_q != IDLE) && (state_q != DONE);
    bus.done             = (state_q == DONE);
    bus.resp_index       = resp_index_q;
    bus.resp_argument    = resp_argument_q;
    bus.crc_error        = crc_error_q;
    bus.end_bit_error    = end_bit_error_q;
    bus.timeout_error    = timeout_error_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_phy.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_phy
// Description : Directed self-checking bench for sd_cmd_phy.
//               Cycle 0 is the cycle in which tx_start is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_phy;

  localparam int TIMEOUT_CYCLES = 64;
  localparam int TURN_CYCLES    = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  sd_cmd_phy_if bus ();

  sd_cmd_phy #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TURN_CYCLES    (TURN_CYCLES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observations gathered by run_cmd for the test tasks to judge.
  logic [47:0] obs_stream;
  int          obs_oi_first, obs_oi_last, obs_oi_cnt;
  int          obs_done_cyc, obs_done_cnt, obs_busy_cnt, obs_en_after;
  logic        obs_crc, obs_eb, obs_to;
  logic [5:0]  obs_idx;
  logic [31:0] obs_arg;

  // Issue one command, optionally play a card response, record what happens.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                         input logic rexp, input logic rchk,
                         input bit drive_rsp, input logic [47:0] rsp,
                         input int dly, input bit poke, input int stop_at);
    int cyc;
    int rsp_base;
    bit fin;
    rsp_base     = 49 + TURN_CYCLES + dly;
    obs_stream   = '0;
    obs_oi_first = -1; obs_oi_last = -1; obs_oi_cnt = 0;
    obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_cnt = 0; obs_en_after = 0;
    @(posedge clock); #1;
    bus.tx_start       = 1'b1;
    bus.cmd_index      = idx;
    bus.cmd_argument   = arg;
    bus.resp_expected  = rexp;
    bus.resp_crc_check = rchk;
    bus.pad_data_out   = 1'b1;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc == 1) begin
        // Scramble inputs after acceptance; the latched command must survive.
        bus.tx_start       = 1'b0;
        bus.cmd_index      = ~idx;
        bus.cmd_argument   = ~arg;
        bus.resp_expected  = ~rexp;
        bus.resp_crc_check = ~rchk;
      end
      if (poke) bus.tx_start = (cyc == 10);
      if (drive_rsp && cyc >= rsp_base && cyc < rsp_base + 48)
        bus.pad_data_out = rsp[47 - (cyc - rsp_base)];
      else
        bus.pad_data_out = 1'b1;
      if (cyc <= 48) obs_stream = {obs_stream[46:0], bus.pad_data_in};
      if (bus.pad_output_input) begin
        if (obs_oi_first < 0) obs_oi_first = cyc;
        obs_oi_last = cyc;
        obs_oi_cnt++;
      end
      if (bus.busy) obs_busy_cnt++;
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = cyc;
          obs_crc = bus.crc_error;
          obs_eb  = bus.end_bit_error;
          obs_to  = bus.timeout_error;
          obs_idx = bus.resp_index;
          obs_arg = bus.resp_argument;
        end
      end else if (obs_done_cyc >= 0 && bus.pad_enable) begin
        obs_en_after++;
      end
      if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 5) fin = 1'b1;
      if (stop_at > 0 && cyc == stop_at) fin = 1'b1;
    end
    bus.tx_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [80:0] outs;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    outs = {bus.pad_data_in, bus.pad_output_input, bus.pad_enable, bus.busy, bus.done,
            bus.crc_error, bus.end_bit_error, bus.timeout_error, bus.resp_index, bus.resp_argument};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({bus.pad_enable, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset got en/busy %b want 00", {bus.pad_enable, bus.busy});
    end
  endtask

  task automatic test_cmd0();
    run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 48'h0, 0, 1'b0, 0);
    checks++;
    if (obs_stream !== 48'h400000000095) begin
      errors++; $display("FAIL cmd0_stream got %h want 400000000095", obs_stream);
    end
    checks++;
    if (obs_oi_first != 1 || obs_oi_last != 49 || obs_oi_cnt != 49) begin
      errors++; $display("FAIL cmd0_oe got %0d..%0d n=%0d want 1..49 n=49", obs_oi_first, obs_oi_last, obs_oi_cnt);
    end
    checks++;
    if (obs_done_cyc != 51 || obs_done_cnt != 1) begin
      errors++; $display("FAIL cmd0_done got cyc %0d n %0d want cyc 51 n 1", obs_done_cyc, obs_done_cnt);
    end
    checks++;
    if (obs_busy_cnt != 50) begin
      errors++; $display("FAIL cmd0_busy got %0d cycles want 50", obs_busy_cnt);
    end
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b000) begin
      errors++; $display("FAIL cmd0_errors got %b want 000", {obs_crc, obs_eb, obs_to});
    end
  endtask

  task automatic test_timeout();
    run_cmd(6'd17, 32'h0, 1'b1, 1'b1, 1'b0, 48'h0, 0, 1'b0, 0);
    checks++;
    if (obs_stream !== 48'h510000000055) begin
      errors++; $display("FAIL cmd17_stream got %h want 510000000055", obs_stream);
    end
    checks++;
    if (obs_done_cyc != 49 + TURN_CYCLES + TIMEOUT_CYCLES || obs_done_cnt != 1) begin
      errors++; $display("FAIL timeout_done got cyc %0d n %0d want cyc %0d n 1",
                         obs_done_cyc, obs_done_cnt, 49 + TURN_CYCLES + TIMEOUT_CYCLES);
    end
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b001) begin
      errors++; $display("FAIL timeout_flags got %b want 001", {obs_crc, obs_eb, obs_to});
    end
    checks++;
    if (obs_oi_last != 49) begin
      errors++; $display("FAIL timeout_oe_last got %0d want 49", obs_oi_last);
    end
  endtask

  task automatic test_cmd8_resp();
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA13, 5, 1'b0, 0);
    checks++;
    if (obs_stream !== 48'h48000001AA87) begin
      errors++; $display("FAIL cmd8_stream got %h want 48000001AA87", obs_stream);
    end
    checks++;
    if (obs_idx !== 6'd8 || obs_arg !== 32'h000001AA) begin
      errors++; $display("FAIL cmd8_resp got idx %0d arg %h want idx 8 arg 000001aa", obs_idx, obs_arg);
    end
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b000) begin
      errors++; $display("FAIL cmd8_errors got %b want 000", {obs_crc, obs_eb, obs_to});
    end
    checks++;
    if (obs_done_cyc != 105) begin
      errors++; $display("FAIL cmd8_done got %0d want 105", obs_done_cyc);
    end
  endtask

  task automatic test_crc_error();
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA11, 0, 1'b0, 0);
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b100) begin
      errors++; $display("FAIL crc_bad_checked got %b want 100", {obs_crc, obs_eb, obs_to});
    end
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b0, 1'b1, 48'h08000001AA11, 0, 1'b0, 0);
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b000) begin
      errors++; $display("FAIL crc_bad_unchecked got %b want 000", {obs_crc, obs_eb, obs_to});
    end
    checks++;
    if (obs_arg !== 32'h000001AA) begin
      errors++; $display("FAIL crc_unchecked_arg got %h want 000001aa", obs_arg);
    end
  endtask

  task automatic test_end_bit_and_busy_start();
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA12, 2, 1'b1, 0);
    checks++;
    if ({obs_crc, obs_eb, obs_to} !== 3'b010) begin
      errors++; $display("FAIL end_bit got %b want 010", {obs_crc, obs_eb, obs_to});
    end
    checks++;
    if (obs_stream !== 48'h48000001AA87) begin
      errors++; $display("FAIL poke_stream got %h want 48000001AA87", obs_stream);
    end
    checks++;
    if (obs_done_cyc != 102 || obs_done_cnt != 1 || obs_en_after != 0) begin
      errors++; $display("FAIL poke_single got cyc %0d n %0d en_after %0d want 102 1 0",
                         obs_done_cyc, obs_done_cnt, obs_en_after);
    end
  endtask

  task automatic test_reset_mid_recv();
    logic [80:0] outs;
    run_cmd(6'd8, 32'h000001AA, 1'b1, 1'b1, 1'b1, 48'h08000001AA13, 0, 1'b0, 80);
    checks++;
    if (bus.pad_enable !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_active got en %b busy %b want 1 1", bus.pad_enable, bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    outs = {bus.pad_data_in, bus.pad_output_input, bus.pad_enable, bus.busy, bus.done,
            bus.crc_error, bus.end_bit_error, bus.timeout_error, bus.resp_index, bus.resp_argument};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL async_reset got %h want 0", outs);
    end
    @(negedge clock) reset = 1'b1;
    run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 1'b0, 48'h0, 0, 1'b0, 0);
    checks++;
    if (obs_stream !== 48'h400000000095 || obs_done_cyc != 51) begin
      errors++; $display("FAIL post_reset_cmd0 got %h done %0d want 400000000095 done 51",
                         obs_stream, obs_done_cyc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset              = 1'b0;
    bus.tx_start       = 1'b0;
    bus.cmd_index      = '0;
    bus.cmd_argument   = '0;
    bus.resp_expected  = 1'b0;
    bus.resp_crc_check = 1'b0;
    bus.pad_data_out   = 1'b1;
    test_reset();
    test_cmd0();
    test_timeout();
    test_cmd8_resp();
    test_crc_error();
    test_end_bit_and_busy_start();
    test_reset_mid_recv();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
